// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub; the optional zero flag
// exists only when ZERO_FLAG_EN is defined.
interface serial_addsub_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             busy;
`ifdef ZERO_FLAG_EN
    logic             zero;
`endif

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf, busy
`ifdef ZERO_FLAG_EN
        , zero
`endif
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf, busy
`ifdef ZERO_FLAG_EN
        , zero
`endif
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder cell plus carry flop, LSB first; ZERO_FLAG_EN adds a zero flag.
// Latency: out_valid rises WIDTH edges after the accepting edge; WIDTH+2 cycles per op at full rate.
// Backpressure: result holds in DONE until out_ready; in_ready is low from accept until DONE is left.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave io
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
`ifdef ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic fa_sum;
    logic fa_co;

    assign fa_sum = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_co  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                    a_d     = io.a;
                    b_d     = io.sub ? ~io.b : io.b;
                    carry_d = io.sub;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
`ifdef ZERO_FLAG_EN
                    zero_d  = ({fa_sum, res_q[WIDTH-1:1]} == '0);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (io.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign io.in_ready  = (state_q == S_IDLE);
    assign io.out_valid = (state_q == S_DONE);
    assign io.busy      = (state_q == S_SHIFT);
    assign io.result    = res_q;
    assign io.cout      = cout_q;
    assign io.ovf       = ovf_q;
`ifdef ZERO_FLAG_EN
    assign io.zero      = zero_q;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=4): directed cases, backpressure,
// mid-operation reset, then randomized operands with random out_ready.
module tb_serial_addsub;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(W)) bus ();
    serial_addsub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

    typedef struct {
        int r;
        int c;
        int o;
        int z;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_rdy = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int ua, input int ub, input bit s);
        exp_t e;
        int sa, sb, uu, ss;
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        uu = s ? ua - ub : ua + ub;
        ss = s ? sa - sb : sa + sb;
        e.r = uu & 15;
        e.c = s ? int'(ua >= ub) : int'(uu > 15);
        e.o = int'(ss > 7 || ss < -8);
        e.z = int'(e.r == 0);
        e.acc = 0;
        return e;
    endfunction

    // Monitor: compare on each rising out_valid against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency", cyc - e.acc, W);
                chk("result", int'(bus.result), e.r);
                chk("cout", int'(bus.cout), e.c);
                chk("ovf", int'(bus.ovf), e.o);
`ifdef ZERO_FLAG_EN
                chk("zero", int'(bus.zero), e.z);
`endif
                chk("in_ready_in_done", int'(bus.in_ready), 0);
            end
        end
        prev_ov = rst_n ? bus.out_valid : 1'b0;
    end

    task automatic do_op(input int ua, input int ub, input bit s);
        exp_t e;
        int n;
        @(negedge clk);
        bus.a = 4'(ua);
        bus.b = 4'(ub);
        bus.sub = s;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
        end else begin
            e = model(ua, ub, s);
            e.acc = cyc + 1;
            exp_q.push_back(e);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        exp_t held;
        int n;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_cout", int'(bus.cout), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        chk("rst_busy", int'(bus.busy), 0);
`ifdef ZERO_FLAG_EN
        chk("rst_zero", int'(bus.zero), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_op(3, 5, 1'b0);
        do_op(7, 2, 1'b1);
        do_op(2, 7, 1'b1);
        do_op(8, 1, 1'b1);
        do_op(15, 1, 1'b0);
        do_op(0, 8, 1'b1);
        do_op(5, 0, 1'b1);
        wait_drain(50);

        // Backpressure: result must hold and no new accept while DONE is stalled
        bus.out_ready = 1'b0;
        do_op(9, 3, 1'b0);
        held = model(9, 3, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", int'(bus.out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a = 4'($urandom_range(0, 15));
            bus.b = 4'($urandom_range(0, 15));
            bus.sub = 1'($urandom_range(0, 1));
            chk("bp_result_held", int'(bus.result), held.r);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_out_valid_held", int'(bus.out_valid), 1);
        end
        @(negedge clk);
        chk("bp_result_held", int'(bus.result), held.r);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", int'(bus.out_valid), 0);
        repeat (8) @(negedge clk);
        chk("bp_no_extra_accept", exp_q.size(), 0);

        // Reset right after the second SHIFT edge
        do_op(5, 3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_result", int'(bus.result), 0);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        chk("abort_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(6, 2, 1'b1);
        wait_drain(50);

        // Randomized operands with random consumer stalls
        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 0;
        bus.out_ready = 1'b1;
        wait_drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial, clocked adder/subtractor. Accepts WIDTH-bit operands A and B and a mode bit over a valid/ready handshake.
- Processes one bit per clock through a single full-adder cell and a carry flip-flop.
- Returns sum/difference, carry and signed-overflow flags over a second valid/ready handshake.
- Sequential, area-minimal companion to the combinational four-bit adder/subtractor; it is the subtract-capable direction of the same full-adder datapath.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set offered
- in_ready  output  1  block can accept an operand set
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- sub  input  1  0 = A+B, 1 = A-B; sampled on accept
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- cout  output  1  final carry out; in sub mode 1 = no borrow (A >= B unsigned)
- ovf  output  1  two's-complement overflow
- busy  output  1  high in SHIFT state

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; bit counter, carry, A/B/result shift registers = 0.
  - in_ready = 1; out_valid = 0; result = 0; cout = 0; ovf = 0; busy = 0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1.
  - Accept on a rising edge with in_valid & in_ready.
  - On accept: load A and B shift registers; if sub, load ~b instead of b; carry = sub; counter = 0; go to SHIFT.
- SHIFT:
  - in_ready = 0; busy = 1.
  - Each edge computes the full adder of the LSBs of the A and B registers plus carry.
  - Sum bit shifts into the result register MSB; A and B registers shift right; carry updates; counter increments.
  - On the edge where counter = WIDTH-1 (the last bit):
    - latch cout = carry-out of that bit;
    - latch ovf = carry-in XOR carry-out of that MSB bit;
    - go to DONE.
- DONE:
  - out_valid = 1; result, cout and ovf stable.
  - On an edge with out_ready = 1: go to IDLE; out_valid drops.
  - result, cout and ovf hold their last values after leaving DONE until the next computation overwrites them.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high.
- out_ready is ignored outside DONE.
- in_valid and operand inputs are ignored outside IDLE; no buffering.
- No combinational path exists from any input to in_ready or out_valid.
- Overflow is judged on the effective operands (A and ~B+1) in sub mode. The most-negative B value is handled correctly by the carry-in = 1 scheme.
- Reset asserted in any state, including mid-SHIFT, aborts the operation immediately. After release the block is in IDLE, accepting, with no stale out_valid.

Optional Feature:
- Macro ZERO_FLAG_EN.
- When defined: extra output port zero (1 bit). It is registered, reset to 0, and updated together with cout/ovf on the last SHIFT edge. zero = 1 when the full WIDTH-bit result equals 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH = 4):
- Add, overflow: a=3, b=5, sub=0, accept, out_ready=1.
  - Required: out_valid exactly 4 edges after accept; result=8, cout=0, ovf=1.
- Subtract, no borrow: a=7, b=2, sub=1.
  - Required: result=5, cout=1, ovf=0.
- Subtract, borrow: a=2, b=7, sub=1.
  - Required: result=4'hB, cout=0, ovf=0.
- Subtract, signed overflow: a=4'h8, b=1, sub=1.
  - Required: result=7, cout=1, ovf=1.
- Carry wrap: a=15, b=1, sub=0.
  - Required: result=0, cout=1, ovf=0; zero=1 with ZERO_FLAG_EN.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles after out_valid while toggling in_valid with new operands. Required: result held, in_ready=0, no new accept.
  - Separately, drop rst_n during the 2nd SHIFT edge. Required: out_valid=0, result=0, in_ready=1 immediately, and a fresh 6-2 computes 4 correctly.
